// File: rtl/pri_arb_n_if.sv
// Request/grant bundle for pri_arb_n: request side inputs and the registered
// valid/ready grant output.
interface pri_arb_n_if #(
  parameter int N = 16
) ();
  localparam int W = $clog2(N);

  logic         enable;
  logic         rr_mode;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_index;
  logic [N-1:0] out_onehot;

  modport master (
    output enable, rr_mode, req, out_ready,
    input  out_valid, out_index, out_onehot
  );

  modport slave (
    input  enable, rr_mode, req, out_ready,
    output out_valid, out_index, out_onehot
  );
endinterface

// File: rtl/pri_arb_n.sv
// N-input arbiter, fixed or round-robin priority, holding one registered
// winner until the consumer accepts it.
module pri_arb_n #(
  parameter int N = 16
) (
  input logic        clock,
  input logic        reset_n,
  pri_arb_n_if.slave bus
);
  localparam int W = $clog2(N);

  logic [W-1:0] ptr_q, ptr_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;

  logic         accept;
  logic         load;
  logic [W-1:0] ptr_next;
  logic [W-1:0] start;
  logic [W:0]   scan;
  logic [W-1:0] cand;
  logic         found;

  assign accept   = valid_q & bus.out_ready;
  assign load     = bus.enable & (|bus.req) & (~valid_q | accept);
  assign ptr_next = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);

  // A back-to-back load searches from the pointer this accept produces.
  always_comb begin
    start = '0;
    if (bus.rr_mode)
      start = accept ? ptr_next : ptr_q;
    scan  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      scan = {1'b0, start} + (W+1)'(i);
      if (scan >= (W+1)'(N))
        scan = scan - (W+1)'(N);
      if (!found && bus.req[scan[W-1:0]]) begin
        found = 1'b1;
        cand  = scan[W-1:0];
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    if (accept) begin
      ptr_d    = ptr_next;
      valid_d  = 1'b0;
      idx_d    = '0;
      onehot_d = '0;
    end
    if (load) begin
      valid_d        = 1'b1;
      idx_d          = cand;
      onehot_d       = '0;
      onehot_d[cand] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_index  = idx_q;
  assign bus.out_onehot = onehot_q;
endmodule

// File: tb/tb_pri_arb_n.sv
// Directed plus randomized bench for pri_arb_n (N=16) against a queue-free
// integer reference model of the grant/pointer rules.
module tb_pri_arb_n;
  localparam int N = 16;

  logic clock;
  logic reset_n;
  int   total;
  int   fails;

  // reference model state
  bit   m_valid;
  int   m_idx;
  int   m_ptr;

  pri_arb_n_if #(.N(N)) bus ();

  pri_arb_n #(.N(N)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [63:0] exp_oh;
    exp_oh = m_valid ? (64'd1 << m_idx) : 64'd0;
    chk({tag, ".valid"},  64'(bus.out_valid),  64'(m_valid));
    chk({tag, ".index"},  64'(bus.out_index),  64'(m_idx));
    chk({tag, ".onehot"}, 64'(bus.out_onehot), exp_oh);
  endtask

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    bit acc;
    int s;
    acc = m_valid && bus.out_ready;
    if (acc) m_ptr = (m_idx + 1) % N;
    if (bus.enable && bus.req != 0 && (!m_valid || acc)) begin
      s = bus.rr_mode ? m_ptr : 0;
      for (int k = 0; k < N; k++) begin
        if (bus.req[(s + k) % N]) begin
          m_idx = (s + k) % N;
          break;
        end
      end
      m_valid = 1;
    end else if (acc) begin
      m_valid = 0;
      m_idx   = 0;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    m_valid = 0; m_idx = 0; m_ptr = 0;
    chk_model("reset_async");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic drive(input bit en, input bit rr, input logic [N-1:0] r, input bit rdy);
    bus.enable = en; bus.rr_mode = rr; bus.req = r; bus.out_ready = rdy;
  endtask

  initial begin
    total = 0; fails = 0;
    m_valid = 0; m_idx = 0; m_ptr = 0;
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 16'hA5A5, 1'b1);
    #2;
    chk_model("reset_hold");
    @(negedge clock);
    reset_n = 1'b1;

    // fixed priority
    drive(1'b1, 1'b0, 16'h0024, 1'b1);
    step("fixed0");
    chk("fixed0.idx2", 64'(bus.out_index), 64'd2);
    chk("fixed0.oh", 64'(bus.out_onehot), 64'h0004);
    step("fixed1");
    chk("fixed1.idx2", 64'(bus.out_index), 64'd2);

    // backpressure hold while req changes
    bus.out_ready = 1'b0;
    step("hold0");
    bus.req = 16'h0001;
    for (int i = 0; i < 3; i++) step("hold");
    chk("hold.idx2", 64'(bus.out_index), 64'd2);
    bus.out_ready = 1'b1;
    step("hold_rel");
    chk("hold_rel.idx0", 64'(bus.out_index), 64'd0);

    // round-robin sweep from reset
    do_reset();
    drive(1'b1, 1'b1, 16'hFFFF, 1'b1);
    for (int i = 0; i < 18; i++) begin
      step("rr_sweep");
      chk("rr_sweep.seq", 64'(bus.out_index), 64'(i % N));
      chk("rr_sweep.vld", 64'(bus.out_valid), 64'd1);
    end
    for (int i = 2; i <= 14; i++) step("rr_to14");
    chk("rr_to14.idx", 64'(bus.out_index), 64'd14);

    // wrap and skip
    bus.req = 16'h0003;
    step("rr_wrap0");
    chk("rr_wrap0.idx", 64'(bus.out_index), 64'd0);
    step("rr_wrap1");
    chk("rr_wrap1.idx", 64'(bus.out_index), 64'd1);
    step("rr_wrap2");
    chk("rr_wrap2.idx", 64'(bus.out_index), 64'd0);
    bus.req = 16'h8001;
    step("rr_skip");
    chk("rr_skip.idx15", 64'(bus.out_index), 64'd15);

    // enable gating
    do_reset();
    drive(1'b0, 1'b1, 16'hFFFF, 1'b1);
    for (int i = 0; i < 3; i++) step("en_off");
    chk("en_off.vld", 64'(bus.out_valid), 64'd0);
    bus.enable = 1'b1; bus.out_ready = 1'b0;
    step("en_grant");
    bus.enable = 1'b0;
    bus.rr_mode = 1'b0;
    for (int i = 0; i < 2; i++) step("en_held");
    chk("en_held.vld", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    step("en_drop");
    chk("en_drop.vld", 64'(bus.out_valid), 64'd0);
    step("en_idle");

    // randomized traffic with occasional mid-hold resets
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = N'(1) << $urandom_range(0, N - 1);
        2: r = N'($urandom) & N'($urandom);
        default: r = N'($urandom);
      endcase
      drive($urandom_range(0, 99) < 85, 1'($urandom), r, $urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) == 0) do_reset();
      else step("rand");
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
